// File: rtl/snitch_lsu_rob.sv
// Snitch load/store unit with a reorder buffer: memory may answer out of order by ID,
// loads are handed back to the core strictly in request order.
module snitch_lsu_rob #(
  parameter int unsigned TagWidth       = 5,
  parameter int unsigned DataWidth      = 32,
  parameter int unsigned NumOutstanding = 4,
  parameter bit          NaNBox         = 1'b0,
  localparam int unsigned IdWidth       = (NumOutstanding > 1) ? $clog2(NumOutstanding) : 1
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [TagWidth-1:0]    lsu_qtag_i,
  input  logic                   lsu_qwrite_i,
  input  logic                   lsu_qsigned_i,
  input  logic [31:0]            lsu_qaddr_i,
  input  logic [DataWidth-1:0]   lsu_qdata_i,
  input  logic [1:0]             lsu_qsize_i,
  input  logic [3:0]             lsu_qamo_i,
  input  logic                   lsu_qvalid_i,
  output logic                   lsu_qready_o,
  output logic [DataWidth-1:0]   lsu_pdata_o,
  output logic [TagWidth-1:0]    lsu_ptag_o,
  output logic                   lsu_perror_o,
  output logic                   lsu_pvalid_o,
  input  logic                   lsu_pready_i,
  output logic                   lsu_empty_o,
  output logic [31:0]            data_qaddr_o,
  output logic                   data_qwrite_o,
  output logic [3:0]             data_qamo_o,
  output logic [DataWidth-1:0]   data_qdata_o,
  output logic [DataWidth/8-1:0] data_qstrb_o,
  output logic [IdWidth-1:0]     data_qid_o,
  output logic                   data_qvalid_o,
  input  logic                   data_qready_i,
  input  logic [DataWidth-1:0]   data_pdata_i,
  input  logic                   data_perror_i,
  input  logic [IdWidth-1:0]     data_pid_i,
  input  logic                   data_pvalid_i,
  output logic                   data_pready_o
);

  localparam int unsigned NumBytes = DataWidth / 8;
  localparam int unsigned OffWidth = $clog2(NumBytes);
  localparam int unsigned CntWidth = $clog2(NumOutstanding + 1);

  // Handshakes: a transfer happens in a cycle where valid and ready are both high;
  // valid never depends on ready, and a stalled request keeps its payload stable.

  logic [NumOutstanding-1:0] alloc_q, alloc_d, done_q, done_d;
  logic [NumOutstanding-1:0] write_q, signed_q, err_q;
  logic [TagWidth-1:0]       tag_q    [NumOutstanding];
  logic [OffWidth-1:0]       offset_q [NumOutstanding];
  logic [1:0]                size_q   [NumOutstanding];
  logic [DataWidth-1:0]      data_q   [NumOutstanding];
  logic [IdWidth-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntWidth-1:0]       count_q, count_d;

  logic                 full, alloc_en, free_en, fill_en, head_done, pid_ok, sign;
  logic [OffWidth-1:0]  offset, fill_off;
  logic [1:0]           fill_size;
  logic [DataWidth-1:0] shifted, fill_data;
  logic [7:0]           ext_byte;

  function automatic logic [IdWidth-1:0] wrap_inc(input logic [IdWidth-1:0] p);
    return (32'(p) == NumOutstanding - 1) ? '0 : p + 1'b1;
  endfunction

  // Request path: fully combinational towards memory.
  assign full          = (count_q == CntWidth'(NumOutstanding));
  assign data_qvalid_o = lsu_qvalid_i & ~full;
  assign lsu_qready_o  = data_qready_i & ~full;
  assign alloc_en      = data_qvalid_o & data_qready_i;
  assign offset        = lsu_qaddr_i[OffWidth-1:0];
  assign data_qaddr_o  = {lsu_qaddr_i[31:OffWidth], {OffWidth{1'b0}}};
  assign data_qwrite_o = lsu_qwrite_i;
  assign data_qamo_o   = lsu_qamo_i;
  assign data_qid_o    = wr_ptr_q;
  assign data_pready_o = 1'b1;

  always_comb begin
    data_qstrb_o = '0;
    data_qdata_o = '0;
    for (int unsigned i = 0; i < NumBytes; i++) begin
      data_qstrb_o[i] = (i >= 32'(offset)) && (i < 32'(offset) + (32'd1 << lsu_qsize_i));
      data_qdata_o[8*i +: 8] = lsu_qdata_i[8*((i + NumBytes - 32'(offset)) % NumBytes) +: 8];
    end
  end

  // Response fill: align the addressed bytes down and extend above the access size.
  assign pid_ok    = (32'(data_pid_i) < NumOutstanding);
  assign fill_en   = data_pvalid_i & pid_ok & alloc_q[data_pid_i] & ~done_q[data_pid_i];
  assign fill_off  = offset_q[data_pid_i];
  assign fill_size = size_q[data_pid_i];
  assign shifted   = data_pdata_i >> {fill_off, 3'b000};

  always_comb begin
    sign = 1'b0;
    for (int unsigned i = 0; i < NumBytes; i++) begin
      if (i == (32'd1 << fill_size) - 32'd1) sign = shifted[8*i+7];
    end
    ext_byte  = NaNBox ? 8'hFF : {8{signed_q[data_pid_i] & sign}};
    fill_data = shifted;
    for (int unsigned i = 0; i < NumBytes; i++) begin
      if (i >= (32'd1 << fill_size)) fill_data[8*i +: 8] = ext_byte;
    end
  end

  // Retire: only the head slot is considered; stores leave without a core response.
  assign head_done    = alloc_q[rd_ptr_q] & done_q[rd_ptr_q];
  assign lsu_pvalid_o = head_done & ~write_q[rd_ptr_q];
  assign free_en      = head_done & (write_q[rd_ptr_q] | lsu_pready_i);
  assign lsu_pdata_o  = data_q[rd_ptr_q];
  assign lsu_ptag_o   = tag_q[rd_ptr_q];
  assign lsu_perror_o = err_q[rd_ptr_q];
  assign lsu_empty_o  = (count_q == '0);

  always_comb begin
    alloc_d  = alloc_q;
    done_d   = done_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (free_en) begin
      alloc_d[rd_ptr_q] = 1'b0;
      rd_ptr_d          = wrap_inc(rd_ptr_q);
    end
    if (fill_en) done_d[data_pid_i] = 1'b1;
    if (alloc_en) begin
      alloc_d[wr_ptr_q] = 1'b1;
      done_d[wr_ptr_q]  = 1'b0;
      wr_ptr_d          = wrap_inc(wr_ptr_q);
    end
    if (alloc_en && !free_en)      count_d = count_q + 1'b1;
    else if (!alloc_en && free_en) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      alloc_q  <= '0;
      done_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      alloc_q  <= alloc_d;
      done_q   <= done_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Slot payload needs no reset: it is only observed once alloc and done are set.
  always_ff @(posedge clk_i) begin
    if (alloc_en) begin
      write_q[wr_ptr_q]  <= lsu_qwrite_i;
      signed_q[wr_ptr_q] <= lsu_qsigned_i;
      tag_q[wr_ptr_q]    <= lsu_qtag_i;
      offset_q[wr_ptr_q] <= offset;
      size_q[wr_ptr_q]   <= lsu_qsize_i;
    end
    if (fill_en) begin
      data_q[data_pid_i] <= fill_data;
      err_q[data_pid_i]  <= data_perror_i;
    end
  end

  stray_resp: assert property (@(posedge clk_i) disable iff (!rst_ni) data_pvalid_i |-> fill_en)
    else $warning("snitch_lsu_rob: response for id %0d dropped (slot idle or already filled)", data_pid_i);

endmodule
